acia_io_arb: RTL and testbench
==============================

ACIA_IO_ARB -- requirements
Module: acia_io_arb

Interface
REQ-001 Parameter GAP_CYCLES, default 11138, 14-bit clk-cycle pause after each delivered byte (pacing builds only).
REQ-002 clk  input  1  system clock (8 MHz), all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ikbd_avail  input  1  ikbd source has a byte ready.
REQ-005 ikbd_data  input  8  ikbd source byte, valid while ikbd_avail=1.
REQ-006 ikbd_pop  output  1  one-cycle pulse, ikbd source advances its read pointer.
REQ-007 midi_avail  input  1  midi source has a byte ready.
REQ-008 midi_data  input  8  midi source byte, valid while midi_avail=1.
REQ-009 midi_pop  output  1  one-cycle pulse, midi source advances its read pointer.
REQ-010 io_available  output  1  held byte presented to io controller.
REQ-011 io_data  output  8  held byte.
REQ-012 io_chan  output  1  held byte's source: 0=ikbd, 1=midi.
REQ-013 io_strobe  input  1  io controller acknowledge, asynchronous to clk, rising edge = byte taken.
REQ-014 busy  output  1  state not IDLE.

Function
REQ-015 FSM states IDLE, HOLD, GAP; encoding free.
REQ-016 io_strobe SHALL pass a 2-flop synchronizer; ack = sync2 high and sync3 (third flop) low; ack latency 2-3 clk after the raw edge.
REQ-017 IDLE, neither avail: stay IDLE, no pop.
REQ-018 IDLE, exactly one avail: latch that source's data and channel, pulse its pop for exactly one cycle (registered), next state HOLD.
REQ-019 IDLE, both avail: grant the source not granted last (round-robin pointer rr); rr reset value grants ikbd first.
REQ-020 rr SHALL update only on a grant, to the granted channel.
REQ-021 io_available=1 exactly while in HOLD; io_data/io_chan stable throughout HOLD.
REQ-022 HOLD, ack: io_available falls next cycle; next state GAP (pacing) or IDLE (no pacing).
REQ-023 GAP loads 14-bit counter with GAP_CYCLES on entry, decrements each cycle, returns to IDLE the cycle after it reads 0; GAP_CYCLES=0 -> one GAP cycle.
REQ-024 Ack outside HOLD SHALL be ignored (no state, pop or pointer change).
REQ-025 Avail changes during HOLD/GAP SHALL not alter the held byte; sources wait.
REQ-026 At most one pop pulse per delivered byte; ikbd_pop and midi_pop never high together.
REQ-027 Minimum byte-to-byte spacing without pacing: grant cycle + HOLD + ack latency; no back-to-back pops on consecutive cycles.

Reset
REQ-028 reset low: state IDLE, rr=midi (so ikbd next), ikbd_pop=0, midi_pop=0, io_available=0, io_data=8'h00, io_chan=0, busy=0, gap counter 0, synchronizer flops 0.
REQ-029 reset mid-HOLD/GAP: held byte discarded (already popped, not re-requested); no pop during or on the cycle reset deasserts.
REQ-030 A strobe high at reset release SHALL not create an ack (flops reset to 0, edge required from a low sample... sync3 follows sync2 so a steady-high input yields at most one ack, only in HOLD).

Configuration
REQ-031 Macro ACIA_IO_ARB_PACE_EN defined: GAP state and counter present, HOLD ack -> GAP.
REQ-032 Macro undefined: no GAP state, no counter, GAP_CYCLES ignored, HOLD ack -> IDLE.

Verification
REQ-033 ikbd_avail=1, data 8'hA5, midi idle -> ikbd_pop one cycle, next cycle io_available=1, io_data=A5, io_chan=0.
REQ-034 Both avail from reset, ikbd 8'h11, midi 8'h22, strobe each byte -> order ikbd, midi, ikbd; io_chan 0,1,0.
REQ-035 HOLD, raw io_strobe rising -> io_available low 3-4 clk after edge; second strobe pulse outside HOLD -> no change.
REQ-036 PACE_EN, GAP_CYCLES=20, ikbd continuously avail -> next ikbd_pop exactly 22 cycles after io_available falls (GAP entry + 21 GAP cycles... count to 0 then IDLE grant); undefined -> pop 1 cycle after io_available falls.
REQ-037 reset low during HOLD with io_chan=1 -> all outputs at reset values, midi_pop never re-pulsed, first grant after release goes to ikbd.
REQ-038 Change ikbd_data during HOLD 8'h3C->8'hC3 -> io_data stays 8'h3C until ack.

Source files
------------

// File: rtl/acia_io_arb.sv
// Two-source (ikbd/midi) round-robin byte arbiter feeding a single io controller.
// Optional post-delivery pacing gap is enabled by defining ACIA_IO_ARB_PACE_EN.
module acia_io_arb #(
  parameter logic [13:0] GAP_CYCLES = 14'd11138
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ikbd_avail,
  input  logic [7:0] ikbd_data,
  output logic       ikbd_pop,
  input  logic       midi_avail,
  input  logic [7:0] midi_data,
  output logic       midi_pop,
  output logic       io_available,
  output logic [7:0] io_data,
  output logic       io_chan,
  input  logic       io_strobe,
  output logic       busy
);

`ifdef ACIA_IO_ARB_PACE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2} state_e;
  logic [13:0] gap_cnt_q, gap_cnt_d;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_e;
  logic [13:0] gap_unused_s;
  assign gap_unused_s = GAP_CYCLES;
`endif

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  logic        ikbd_pop_q, ikbd_pop_d;
  logic        midi_pop_q, midi_pop_d;
  logic        io_avail_q, io_avail_d;
  logic [7:0]  io_data_q, io_data_d;
  logic        io_chan_q, io_chan_d;
  logic        busy_q, busy_d;
  logic [2:0]  sync_q, sync_d;
  logic        ack_s;
  logic        grant_midi_s;

  // sync_q[0..1] is the synchronizer, sync_q[2] remembers the previous level
  assign sync_d = {sync_q[1:0], io_strobe};
  assign ack_s  = sync_q[1] & ~sync_q[2];

  // midi wins when it is alone, or when both wait and ikbd was granted last
  assign grant_midi_s = midi_avail & (~ikbd_avail | ~rr_q);

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    ikbd_pop_d = 1'b0;
    midi_pop_d = 1'b0;
    io_data_d  = io_data_q;
    io_chan_d  = io_chan_q;
`ifdef ACIA_IO_ARB_PACE_EN
    gap_cnt_d  = gap_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (ikbd_avail | midi_avail) begin
          state_d    = HOLD;
          rr_d       = grant_midi_s;
          io_chan_d  = grant_midi_s;
          io_data_d  = grant_midi_s ? midi_data : ikbd_data;
          ikbd_pop_d = ~grant_midi_s;
          midi_pop_d = grant_midi_s;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (ack_s) begin
`ifdef ACIA_IO_ARB_PACE_EN
          state_d   = GAP;
          gap_cnt_d = GAP_CYCLES;
`else
          state_d   = IDLE;
`endif
        end else begin
          state_d = HOLD;
        end
      end
`ifdef ACIA_IO_ARB_PACE_EN
      GAP: begin
        if (gap_cnt_q == 14'd0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 14'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    io_avail_d = (state_d == HOLD);
    busy_d     = (state_d != IDLE);
  end

  // state, pointer, synchronizer and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_q       <= 1'b1;
      ikbd_pop_q <= 1'b0;
      midi_pop_q <= 1'b0;
      io_avail_q <= 1'b0;
      io_data_q  <= 8'h00;
      io_chan_q  <= 1'b0;
      busy_q     <= 1'b0;
      sync_q     <= 3'b000;
`ifdef ACIA_IO_ARB_PACE_EN
      gap_cnt_q  <= 14'd0;
`endif
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      ikbd_pop_q <= ikbd_pop_d;
      midi_pop_q <= midi_pop_d;
      io_avail_q <= io_avail_d;
      io_data_q  <= io_data_d;
      io_chan_q  <= io_chan_d;
      busy_q     <= busy_d;
      sync_q     <= sync_d;
`ifdef ACIA_IO_ARB_PACE_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  assign ikbd_pop     = ikbd_pop_q;
  assign midi_pop     = midi_pop_q;
  assign io_available = io_avail_q;
  assign io_data      = io_data_q;
  assign io_chan      = io_chan_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_acia_io_arb.sv
// Self-checking bench for acia_io_arb: vector table with scoreboard, plus
// hand sequences for strobe latency, pacing, reset mid-hold and strobe-at-reset.
module tb_acia_io_arb;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ikbd_avail = 1'b0;
  logic [7:0] ikbd_data = 8'h00;
  logic       ikbd_pop;
  logic       midi_avail = 1'b0;
  logic [7:0] midi_data = 8'h00;
  logic       midi_pop;
  logic       io_available;
  logic [7:0] io_data;
  logic       io_chan;
  logic       io_strobe = 1'b0;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       ia;
    logic [7:0] id;
    logic       ma;
    logic [7:0] md;
    logic       ec;
    logic [7:0] ed;
  } vec_t;

  vec_t       vecs[9];
  logic [8:0] sb_q[$];

  acia_io_arb #(.GAP_CYCLES(14'd20)) dut (
    .clk(clk), .reset(reset),
    .ikbd_avail(ikbd_avail), .ikbd_data(ikbd_data), .ikbd_pop(ikbd_pop),
    .midi_avail(midi_avail), .midi_data(midi_data), .midi_pop(midi_pop),
    .io_available(io_available), .io_data(io_data), .io_chan(io_chan),
    .io_strobe(io_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_hold(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (io_available) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack_byte(output int n);
    io_strobe = 1'b1;
    n = 0;
    while (io_available && n < 10) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 60) begin
      tick();
      k++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    bit         ok;
    int         n;
    int         k;
    logic [8:0] exp;

    vecs[0] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 8'h11};
    vecs[1] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 8'h22};
    vecs[2] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 8'h11};
    vecs[3] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'hA5};
    vecs[4] = '{1'b1, 8'h33, 1'b1, 8'h44, 1'b1, 8'h44};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 8'h5A};
    vecs[6] = '{1'b1, 8'h00, 1'b1, 8'h80, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 8'hF0, 1'b1, 8'hF0};
    vecs[8] = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'hFF};

    tick();
    tick();
    chk("rst_io_available", {31'd0, io_available}, 32'd0);
    chk("rst_io_data", {24'd0, io_data}, 32'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pops", {30'd0, ikbd_pop, midi_pop}, 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_no_pop", {30'd0, ikbd_pop, midi_pop}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      ikbd_avail = vecs[i].ia;
      ikbd_data  = vecs[i].id;
      midi_avail = vecs[i].ma;
      midi_data  = vecs[i].md;
      sb_q.push_back({vecs[i].ec, vecs[i].ed});
      wait_hold(ok);
      exp = sb_q.pop_front();
      chk($sformatf("v%0d_grant_timeout", i), {31'd0, ok}, 32'd1);
      if (ok) begin
        chk($sformatf("v%0d_io_data", i), {24'd0, io_data}, {24'd0, exp[7:0]});
        chk($sformatf("v%0d_io_chan", i), {31'd0, io_chan}, {31'd0, exp[8]});
        chk($sformatf("v%0d_pops", i), {30'd0, ikbd_pop, midi_pop}, {30'd0, ~exp[8], exp[8]});
        ikbd_avail = 1'b0;
        midi_avail = 1'b0;
        ikbd_data  = ~vecs[i].id;
        midi_data  = ~vecs[i].md;
        tick();
        chk($sformatf("v%0d_pop_once", i), {30'd0, ikbd_pop, midi_pop}, 32'd0);
        tick();
        tick();
        chk($sformatf("v%0d_hold_stable", i), {23'd0, io_available, io_data}, {23'd1, exp[7:0]});
        ack_byte(n);
        chk($sformatf("v%0d_ack_latency_ok(n=%0d)", i, n), {31'd0, (n >= 3 && n <= 4)}, 32'd1);
        io_strobe = 1'b0;
        wait_idle();
      end
    end

    // strobe pulse while idle must be ignored
    io_strobe = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("idle_strobe_ignored", {29'd0, busy, ikbd_pop, midi_pop}, 32'd0);
    end
    io_strobe = 1'b0;
    tick();
    tick();
    tick();

    // byte-to-byte spacing with ikbd continuously available
    ikbd_avail = 1'b1;
    ikbd_data  = 8'h77;
    wait_hold(ok);
    chk("gap_first_hold", {23'd0, ok, io_data}, {23'd1, 8'h77});
    ack_byte(n);
    io_strobe = 1'b0;
    k = 0;
    while (!ikbd_pop && k < 40) begin
      tick();
      k++;
    end
`ifdef ACIA_IO_ARB_PACE_EN
    chk("gap_pop_spacing", k, 32'd22);
`else
    chk("gap_pop_spacing", k, 32'd1);
`endif
    ikbd_avail = 1'b0;
    ack_byte(n);
    io_strobe = 1'b0;
    wait_idle();

    // reset while holding a midi byte
    midi_avail = 1'b1;
    midi_data  = 8'h99;
    wait_hold(ok);
    chk("rsthold_chan", {23'd0, io_chan, io_data}, {23'd1, 8'h99});
    ikbd_avail = 1'b1;
    ikbd_data  = 8'h3C;
    reset = 1'b0;
    #1;
    chk("rsthold_outputs", {19'd0, io_available, io_data, io_chan, busy, ikbd_pop, midi_pop}, 32'd0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("rsthold_no_midi_pop", {31'd0, midi_pop}, 32'd0);
    end
    reset = 1'b1;
    tick();
    chk("rsthold_first_grant", {21'd0, ikbd_pop, midi_pop, io_chan, io_data}, {21'd0, 1'b1, 1'b0, 1'b0, 8'h3C});
    ikbd_avail = 1'b0;
    midi_avail = 1'b0;
    ikbd_data  = 8'hC3;
    tick();
    tick();
    chk("hold_data_change", {24'd0, io_data}, 32'h3C);
    ack_byte(n);
    io_strobe = 1'b0;
    wait_idle();

    // strobe already high at reset release must not produce an ack
    io_strobe = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int j = 0; j < 5; j++) tick();
    ikbd_avail = 1'b1;
    ikbd_data  = 8'h5C;
    wait_hold(ok);
    ikbd_avail = 1'b0;
    for (int j = 0; j < 8; j++) tick();
    chk("steady_strobe_no_ack", {23'd0, io_available, io_data}, {23'd1, 8'h5C});
    io_strobe = 1'b0;
    tick();
    tick();
    ack_byte(n);
    chk($sformatf("final_ack_ok(n=%0d)", n), {31'd0, (n >= 3 && n <= 4)}, 32'd1);
    io_strobe = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
